// File: rtl/piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_pkg
//   Shared definitions for the PISO transmitter and its matching SIPO receiver:
//   FSM state encoding, frame-length and counter-width helpers.
//   Optional feature macro: PISO_TX_PARITY_EN (appends an even-parity bit).
// -----------------------------------------------------------------------------
package piso_tx_pkg;

   // Transmitter state encoding; shared so the receiver decodes the same values.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

`ifdef PISO_TX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Number of serial bits per frame: data bits plus the optional parity bit.
   function automatic int frame_len(input int width);
      return PARITY_EN ? (width + 1) : width;
   endfunction

   // Bit-counter width able to index every bit of a frame, never below 1.
   function automatic int cnt_width(input int frame);
      return (frame > 1) ? $clog2(frame) : 1;
   endfunction

endpackage : piso_tx_pkg

// File: rtl/piso_bit_cnt.sv
// -----------------------------------------------------------------------------
// piso_bit_cnt
//   Frame bit counter for the PISO transmitter. Clear has priority over
//   enable; tc flags the final bit of the frame (cnt == FRAME-1).
//   Asynchronous active-high reset.
// -----------------------------------------------------------------------------
module piso_bit_cnt #(
   parameter int FRAME = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear to the first bit, advance one bit, or hold.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with asynchronous reset to the first bit position.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the pre-edge values; blocking (=) here would create ordering races.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == LAST_IDX);

endmodule : piso_bit_cnt

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx
//   Parallel-in serial-out transmitter. A WIDTH-bit word is captured on
//   load & ready and shifted out one bit per clk with so_valid and last
//   framing. A word accepted while the final bit is on the line streams out
//   with no gap cycle. All serial outputs are registered; ready is
//   combinational from registered state and rst.
//   Optional feature macro: PISO_TX_PARITY_EN -- when defined, an even-parity
//   bit (^pi of the captured word) follows the data bits and carries last.
// -----------------------------------------------------------------------------
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] pi,
   output logic             ready,
   output logic             so,
   output logic             so_valid,
   output logic             last,
   output logic             busy
);

   localparam int FRAME = frame_len(WIDTH);
   localparam int CNT_W = cnt_width(FRAME);

   // Counter value of the second-to-last bit: the next advance lands on last.
   localparam logic [CNT_W-1:0] PRE_LAST_IDX = CNT_W'(FRAME - 2);

   // Registered state and outputs.
   state_e           state_q, state_d;
   logic             so_q, so_d;
   logic             so_valid_q, so_valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   // Bits still waiting to be sent; bit 0 goes out next.
   logic [FRAME-1:0] shreg_q, shreg_d;

   // Counter interface.
   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt;
   logic             tc;

   // Handshake and the captured word in transmit order.
   logic             accept;
   logic [FRAME-1:0] frame_word;

   piso_bit_cnt #(
      .FRAME (FRAME),
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (tc)
   );

   // Accept in IDLE, or on the final bit so back-to-back frames have no gap.
   assign ready  = ~rst & ((state_q == IDLE) | ((state_q == SHIFT) & tc));
   assign accept = load & ready;

   // Reorder pi so frame_word[0] is the first bit on the line.
   always_comb begin
      frame_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         frame_word[i] = MSB_FIRST ? pi[WIDTH-1-i] : pi[i];
      end
`ifdef PISO_TX_PARITY_EN
      // Even parity over the data word, sent after the data bits.
      frame_word[FRAME-1] = ^pi;
`endif
   end

   // Next-state and next-output logic for the IDLE/SHIFT sequencer.
   always_comb begin
      state_d    = state_q;
      so_d       = so_q;
      so_valid_d = so_valid_q;
      last_d     = last_q;
      busy_d     = busy_q;
      shreg_d    = shreg_q;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;

      if (accept) begin
         // New frame: first bit straight to so, remainder into the shifter.
         state_d    = SHIFT;
         so_d       = frame_word[0];
         shreg_d    = frame_word >> 1;
         so_valid_d = 1'b1;
         busy_d     = 1'b1;
         last_d     = 1'b0;
         cnt_clr    = 1'b1;
      end else if (state_q == SHIFT) begin
         if (tc) begin
            // Final bit done with nothing queued: return to a quiet line.
            state_d    = IDLE;
            so_d       = 1'b0;
            so_valid_d = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            shreg_d    = '0;
            cnt_clr    = 1'b1;
         end else begin
            so_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            last_d  = (cnt == PRE_LAST_IDX);
            cnt_en  = 1'b1;
         end
      end
   end

   // State, shifter and registered outputs; reset aborts any frame at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         so_q       <= 1'b0;
         so_valid_q <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         // NOTE: the shifter is a plain flop vector, not a memory, so it is
         // reset; that keeps so deterministic and avoids X on the line.
         shreg_q    <= '0;
      end else begin
         state_q    <= state_d;
         so_q       <= so_d;
         so_valid_q <= so_valid_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         shreg_q    <= shreg_d;
      end
   end

   assign so       = so_q;
   assign so_valid = so_valid_q;
   assign last     = last_q;
   assign busy     = busy_q;

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx
//   Self-checking bench for piso_tx (WIDTH=4). Two instances share stimulus:
//   dut_m sends MSB first, dut_l sends LSB first. The reference model is a
//   queue of bits still to appear on each line; the head is the bit on so,
//   a one-entry queue means last is showing. Honours PISO_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_tx;

   localparam int WIDTH = 4;
`ifdef PISO_TX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
   bit e2m [FRAME]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   bit e2l [FRAME]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   bit e3  [2*FRAME] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                         1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   bit e5  [FRAME]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
   localparam int FRAME = WIDTH;
   bit e2m [FRAME]   = '{1'b1, 1'b1, 1'b0, 1'b1};
   bit e2l [FRAME]   = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit e3  [2*FRAME] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   bit e5  [FRAME]   = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             load;
   logic [WIDTH-1:0] pi;

   logic ready_m, so_m, so_valid_m, last_m, busy_m;
   logic ready_l, so_l, so_valid_l, last_l, busy_l;

   piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .pi       (pi),
      .ready    (ready_m),
      .so       (so_m),
      .so_valid (so_valid_m),
      .last     (last_m),
      .busy     (busy_m)
   );

   piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .pi       (pi),
      .ready    (ready_l),
      .so       (so_l),
      .so_valid (so_valid_l),
      .last     (last_l),
      .busy     (busy_l)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   bit q_m[$];
   bit q_l[$];
   bit m_acc;

   function automatic void push_frame(input logic [WIDTH-1:0] w);
      for (int i = 0; i < WIDTH; i++) begin
         q_m.push_back(w[WIDTH-1-i]);
         q_l.push_back(w[i]);
      end
      if (FRAME > WIDTH) begin
         q_m.push_back(^w);
         q_l.push_back(^w);
      end
   endfunction

   function automatic bit model_ready();
      return (rst === 1'b0) && (q_m.size() <= 1);
   endfunction

   always @(posedge clk) begin
      if (rst !== 1'b0) begin
         q_m.delete();
         q_l.delete();
      end else begin
         m_acc = (load === 1'b1) && model_ready();
         if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
         end
         if (m_acc) push_frame(pi);
      end
   end

   always @(posedge rst) begin
      q_m.delete();
      q_l.delete();
   end

   // ---------------- compare process ----------------
   bit cmp_en = 1'b0;
   bit ev;
   bit el;

   always @(negedge clk) begin
      if (cmp_en) begin
         ev = (q_m.size() > 0);
         el = (q_m.size() == 1);
         check("cmp_ready_m", ready_m,    model_ready());
         check("cmp_valid_m", so_valid_m, ev);
         check("cmp_busy_m",  busy_m,     ev);
         check("cmp_last_m",  last_m,     el);
         check("cmp_so_m",    so_m,       ev ? q_m[0] : 1'b0);
         check("cmp_ready_l", ready_l,    model_ready());
         check("cmp_valid_l", so_valid_l, ev);
         check("cmp_last_l",  last_l,     el);
         check("cmp_so_l",    so_l,       ev ? q_l[0] : 1'b0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic l, input logic [WIDTH-1:0] p);
      load = l;
      pi   = p;
      @(negedge clk);
   endtask

   task automatic check_quiet(input string name);
      check({name, "_so"},    so_m,       1'b0);
      check({name, "_valid"}, so_valid_m, 1'b0);
      check({name, "_last"},  last_m,     1'b0);
      check({name, "_busy"},  busy_m,     1'b0);
      check({name, "_ready"}, ready_m,    1'b0);
   endtask

   initial begin
      rst  = 1'b1;
      load = 1'b0;
      pi   = '0;
      @(negedge clk);
      @(negedge clk);
      check_quiet("reset_init");
      #2 rst = 1'b0;
      @(negedge clk);
      check("idle_ready", ready_m, 1'b1);
      cmp_en = 1'b1;

      // Single frame 1101 on both bit orders, last on the final bit only.
      drive(1'b1, 4'b1101);
      for (int i = 0; i < FRAME; i++) begin
         check("t2_so",     so_m,       e2m[i]);
         check("t2_valid",  so_valid_m, 1'b1);
         check("t2_last",   last_m,     (i == FRAME - 1));
         check("t6_lsb_so", so_l,       e2l[i]);
         drive(1'b0, '0);
      end
      check("t2_idle_valid", so_valid_m, 1'b0);
      check("t2_idle_busy",  busy_m,     1'b0);

      // Back-to-back frames: second word loaded while last is showing.
      drive(1'b1, 4'b1010);
      for (int i = 0; i < 2 * FRAME; i++) begin
         check("t3_so",    so_m,       e3[i]);
         check("t3_valid", so_valid_m, 1'b1);
         if (i == FRAME - 1) check("t3_ready_on_last", ready_m, 1'b1);
         drive(i == FRAME - 1, 4'b0110);
      end
      check("t3_idle_valid", so_valid_m, 1'b0);

      // Load while busy mid-frame is ignored.
      drive(1'b1, 4'b1101);
      for (int i = 0; i < FRAME; i++) begin
         check("t4_so", so_m, e2m[i]);
         drive(i == 1, (i == 1) ? 4'b1110 : 4'b0000);
      end
      check("t4_idle_valid", so_valid_m, 1'b0);

      // Reset after two bits aborts the frame; next frame is clean.
      drive(1'b1, 4'b1101);
      check("t5_bit0", so_m, 1'b1);
      drive(1'b0, '0);
      check("t5_bit1", so_m, 1'b1);
      #2 rst = 1'b1;
      #1 check_quiet("t5_rst_now");
      @(negedge clk);
      check_quiet("t5_rst_held");
      #2 rst = 1'b0;
      drive(1'b1, 4'b1110);
      for (int i = 0; i < FRAME; i++) begin
         check("t5_so",   so_m,   e5[i]);
         check("t5_last", last_m, (i == FRAME - 1));
         drive(1'b0, '0);
      end
      check("t5_idle_valid", so_valid_m, 1'b0);

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            #2 rst = 1'b0;
         end else begin
            drive($urandom_range(0, 99) < 60, WIDTH'($urandom));
         end
      end

      drive(1'b0, '0);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_piso_tx
